// File: rtl/mont_domain_converter.sv
// mont_domain_converter: bit-serial conversion of a plain operand x into
// Montgomery form x_m = (x * 2^m_bl) mod m, ahead of the Montgomery core.
// Horner evaluation over x[DL-1..0] followed by m_bl zero bits, with one
// conditional subtract per cycle.
// Optional build macro: MONT_CONV_ERR_EN adds err_o and operand legality checks.
module mont_domain_converter #(
  parameter int DATA_LENGTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_LENGTH-1:0] x_m_o,
  output logic                   busy_o
`ifdef MONT_CONV_ERR_EN
  ,
  output logic                   err_o
`endif
);

  localparam int CW = $clog2(2 * DATA_LENGTH) + 1;
  localparam logic [CW-1:0]          DL_C  = CW'(DATA_LENGTH);
  localparam logic [DATA_LENGTH-1:0] DL_W  = DATA_LENGTH'(DATA_LENGTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One Horner step: t = 2*acc + b is below 2*m, so one subtract reduces it.
  function automatic logic [DATA_LENGTH-1:0] mod_step(
    input logic [DATA_LENGTH:0]   t,
    input logic [DATA_LENGTH-1:0] m
  );
    logic [DATA_LENGTH:0] mx;
    mx = {1'b0, m};
    if (t >= mx) return DATA_LENGTH'(t - mx);
    else         return DATA_LENGTH'(t);
  endfunction

  // Clamp the bit length so an illegal value still yields a finite run.
  function automatic logic [CW-1:0] clamp_bl(input logic [DATA_LENGTH-1:0] bl);
    if (bl >= DL_W) return DL_C - CW'(1);
    else            return CW'(bl);
  endfunction

  logic [1:0]             state_q, state_d;
  logic [DATA_LENGTH-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [DATA_LENGTH-1:0] x_q, m_q;
  logic [CW-1:0]          mbl_q;
  logic [CW-1:0]          n_last;
  logic                   accept;
  logic                   in_err;

  assign accept = (state_q == S_IDLE) && valid_i;
  assign n_last = DL_C + mbl_q - CW'(1);

`ifdef MONT_CONV_ERR_EN
  assign in_err = (m_i == '0) || !m_i[0] || (m_bl_i >= DL_W);
`else
  assign in_err = 1'b0;
`endif

  // Next-state logic for the IDLE/RUN/DONE controller and accumulator.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_RUN;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = in_err;
        end
      end
      S_RUN: begin
        if (err_q) begin
          state_d = S_DONE;
        end else begin
          acc_d = mod_step({acc_q, x_q[DATA_LENGTH-1]}, m_q);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == n_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller and accumulator registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Operand capture on accept; x shifts out MSB-first, then feeds zeros.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      x_q   <= x_i;
      m_q   <= m_i;
      mbl_q <= clamp_bl(m_bl_i);
    end else if (state_q == S_RUN) begin
      x_q <= {x_q[DATA_LENGTH-2:0], 1'b0};
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign busy_o  = (state_q == S_RUN) || (state_q == S_DONE);
  assign x_m_o   = (valid_o && !err_q) ? acc_q : '0;
`ifdef MONT_CONV_ERR_EN
  assign err_o   = valid_o && err_q;
`endif

endmodule

// File: tb/tb_mont_domain_converter.sv
// Directed bench for mont_domain_converter (DATA_LENGTH = 64).
module tb_mont_domain_converter;

  localparam int DL = 64;
  localparam logic [63:0] QD = 64'h7FE001;
  localparam logic [63:0] QK = 64'hD01;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_o, valid_o, ready_i, busy_o;
  logic [DL-1:0] x_i, m_i, m_bl_i, x_m_o;
  logic          err_s;
`ifdef MONT_CONV_ERR_EN
  logic          err_o;
`endif

  int tests = 0;
  int fails = 0;

  mont_domain_converter #(.DATA_LENGTH(DL)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .x_i     (x_i),
    .m_i     (m_i),
    .m_bl_i  (m_bl_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .x_m_o   (x_m_o),
    .busy_o  (busy_o)
`ifdef MONT_CONV_ERR_EN
    ,
    .err_o   (err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the accept cycle until valid_o is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction with ready_i=1: accept, wait, sample, handshake.
  task automatic run_op(input logic [63:0] x, input logic [63:0] m, input logic [63:0] bl,
                        output logic [63:0] res, output int lat);
    x_i = x; m_i = m; m_bl_i = bl; valid_i = 1'b1; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    x_i = 64'hDEAD_BEEF_0BAD_F00D; m_i = 64'h3; m_bl_i = 64'd5;
    wait_valid(lat);
    res = x_m_o;
`ifdef MONT_CONV_ERR_EN
    err_s = err_o;
`else
    err_s = 1'b0;
`endif
    tick();
  endtask

  logic [63:0]     res;
  int              lat;
  longint unsigned kmod;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    x_i = '0; m_i = '0; m_bl_i = '0;
    tick(); tick();
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_xm",    x_m_o, 0);
    rst_i = 1'b0;
    tick();

    run_op(64'd1, QD, 64'd23, res, lat);
    check("dil_x1", res, 64'h1FFF);
    check("dil_x1_lat", lat, 88);
    check("dil_x1_after_valid", valid_o, 0);
    check("dil_x1_after_ready", ready_o, 1);
    run_op(64'd0, QD, 64'd23, res, lat);
    check("dil_x0", res, 0);
    run_op(QD, QD, 64'd23, res, lat);
    check("dil_xq", res, 0);
    run_op(64'h7FE000, QD, 64'd23, res, lat);
    check("dil_xqm1", res, 64'h7FC002);

    run_op(64'd1, QK, 64'd12, res, lat);
    check("kyb_x1", res, 64'h2FF);
    check("kyb_x1_lat", lat, 77);
    kmod = (64'hFFFF_FFFF_FFFF_FFFF % 64'd3329) * 64'd767 % 64'd3329;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, QK, 64'd12, res, lat);
    check("kyb_xmax", res, kmod);

    run_op(64'd100, 64'd7, 64'd0, res, lat);
    check("mbl0_res", res, 64'd2);
    check("mbl0_lat", lat, 65);

    // Backpressure window with ignored valid_i pulses.
    x_i = 64'd1; m_i = QD; m_bl_i = 64'd23; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    check("bp_busy", busy_o, 1);
    check("bp_ready", ready_o, 0);
    wait_valid(lat);
    check("bp_lat", lat, 88);
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1;
      x_i = {$urandom, $urandom};
      tick();
      check("bp_hold_valid", valid_o, 1);
      check("bp_hold_xm", x_m_o, 64'h1FFF);
      check("bp_hold_ready", ready_o, 0);
    end
    // Handshake and new valid_i in the same cycle.
    x_i = 64'h7FE000; m_i = QD; m_bl_i = 64'd23; valid_i = 1'b1; ready_i = 1'b1;
    tick();
    check("hs_valid_drop", valid_o, 0);
    check("hs_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    check("hs_accept_busy", busy_o, 1);
    wait_valid(lat);
    check("hs_res", x_m_o, 64'h7FC002);
    check("hs_lat", lat, 88);
    tick();

    // Reset during RUN.
    x_i = 64'd1; m_i = QD; m_bl_i = 64'd23; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_ready", ready_o, 1);
    check("midrst_valid", valid_o, 0);
    check("midrst_xm", x_m_o, 0);
    check("midrst_busy", busy_o, 0);
    run_op(64'd1, QD, 64'd23, res, lat);
    check("postrst_res", res, 64'h1FFF);
    check("postrst_lat", lat, 88);

`ifdef MONT_CONV_ERR_EN
    run_op(64'd5, 64'h10, 64'd5, res, lat);
    check("err_even", err_s, 1);
    check("err_even_xm", res, 0);
    check("err_even_lat", lat, 2);
    check("err_even_clr", err_o, 0);
    run_op(64'd5, 64'd0, 64'd1, res, lat);
    check("err_zero", err_s, 1);
    check("err_zero_xm", res, 0);
    check("err_zero_lat", lat, 2);
    run_op(64'd5, QD, 64'd64, res, lat);
    check("err_bl", err_s, 1);
    run_op(64'd1, QD, 64'd23, res, lat);
    check("err_ok", err_s, 0);
    check("err_ok_xm", res, 64'h1FFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
